// File: rtl/rom_fetch_master_pkg.sv
// Shared constants for the ROM instruction fetch master: FSM encoding,
// fetch stride and default prefetch depth.
package rom_fetch_master_pkg;

    localparam logic [0:0] ST_FETCH = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    localparam int unsigned WORD_STRIDE   = 4;
    localparam int unsigned DEFAULT_DEPTH = 4;

endpackage

// File: rtl/rom_fetch_master_if.sv
// Wishbone instruction-bus bundle between the fetch master and the ROM responder.
interface rom_fetch_master_if #(
    parameter int unsigned ADDR_WIDTH = 15,
    parameter int unsigned DATA_WIDTH = 32
);

    logic [ADDR_WIDTH-1:0] wb_adr_o;
    logic                  wb_stb_o;
    logic [DATA_WIDTH-1:0] wb_dat_i;
    logic                  wb_ack_i;

    modport master (
        output wb_adr_o,
        output wb_stb_o,
        input  wb_dat_i,
        input  wb_ack_i
    );

    modport slave (
        input  wb_adr_o,
        input  wb_stb_o,
        output wb_dat_i,
        output wb_ack_i
    );

endinterface

// File: rtl/rom_fetch_master_fetch_fifo.sv
// DEPTH-entry synchronous FIFO with clear and occupancy count; head reads as 0 when empty.
module fetch_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        do_push = push && (cnt_q != CNT_W'(DEPTH));
        do_pop  = pop && (cnt_q != '0);
        if (clear) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_q] = din;
                wr_d        = wr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_d = rd_q + PTR_W'(1);
            end
            cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset: the head is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign dout  = (cnt_q != '0) ? mem_q[rd_q] : '0;
    assign count = cnt_q;

endmodule

// File: rtl/rom_fetch_master.sv
// Wishbone fetch master streaming ROM words into a prefetch FIFO, with redirect flush.
// Define FETCH_STATS_EN to add the stat_stall_cnt consumer-starvation counter port.
module rom_fetch_master
    import rom_fetch_master_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 15,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = DEFAULT_DEPTH,
    parameter int unsigned RESET_PC   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  instr_valid,
    output logic [DATA_WIDTH-1:0] instr_data,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    input  logic                  instr_ready,
    rom_fetch_master_if.master    wb
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]           stat_stall_cnt
`endif
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [0:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic                  stb_q, stb_d;
    logic [ADDR_WIDTH-1:0] adr_q, adr_d;
    logic [CNT_W-1:0]      outstanding_q, outstanding_d;
    logic [CNT_W-1:0]      discard_cnt_q, discard_cnt_d;

    logic                  ack_ok;
    logic                  issue;
    logic [CNT_W:0]        credit_used;
    logic [CNT_W-1:0]      remaining;
    logic                  fifo_push;
    logic                  tag_pop;
    logic                  instr_pop;
    logic [CNT_W-1:0]      fifo_count;
    logic [ADDR_WIDTH-1:0] tag_head;
    logic [CNT_W-1:0]      tag_cnt_unused;
    logic [ADDR_WIDTH+DATA_WIDTH-1:0] fifo_dout;

    assign instr_pop = instr_valid && instr_ready;

    always_comb begin
        // Outstanding counts the request currently on the bus, so credit covers its ack.
        ack_ok      = wb.wb_ack_i && (outstanding_q != '0);
        credit_used = {1'b0, fifo_count} + {1'b0, outstanding_q};
        issue       = (state_q == ST_FETCH) && en && !redirect_valid
                      && (credit_used < (CNT_W+1)'(DEPTH));
        remaining   = outstanding_q - CNT_W'(ack_ok);

        state_d       = state_q;
        discard_cnt_d = discard_cnt_q;
        fifo_push     = 1'b0;
        tag_pop       = 1'b0;
        outstanding_d = remaining + CNT_W'(issue);
        stb_d         = issue;
        adr_d         = issue ? fetch_pc_q : adr_q;
        fetch_pc_d    = issue ? fetch_pc_q + ADDR_WIDTH'(WORD_STRIDE) : fetch_pc_q;

        if (redirect_valid) begin
            fetch_pc_d    = redirect_pc & ~ADDR_WIDTH'(3);
            discard_cnt_d = remaining;
            state_d       = (remaining != '0) ? ST_FLUSH : ST_FETCH;
        end else if (state_q == ST_FETCH) begin
            fifo_push = ack_ok;
            tag_pop   = ack_ok;
        end else if (ack_ok) begin
            discard_cnt_d = discard_cnt_q - CNT_W'(1);
            if (discard_cnt_q == CNT_W'(1)) begin
                state_d = ST_FETCH;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_FETCH;
            fetch_pc_q    <= ADDR_WIDTH'(RESET_PC);
            stb_q         <= 1'b0;
            adr_q         <= ADDR_WIDTH'(RESET_PC);
            outstanding_q <= '0;
            discard_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            stb_q         <= stb_d;
            adr_q         <= adr_d;
            outstanding_q <= outstanding_d;
            discard_cnt_q <= discard_cnt_d;
        end
    end

    assign wb.wb_stb_o = stb_q;
    assign wb.wb_adr_o = adr_q;

    fetch_fifo #(
        .WIDTH (ADDR_WIDTH),
        .DEPTH (DEPTH)
    ) u_tag_queue (
        .clk   (clk),
        .rst   (rst),
        .clear (redirect_valid),
        .push  (issue),
        .din   (fetch_pc_q),
        .pop   (tag_pop),
        .dout  (tag_head),
        .count (tag_cnt_unused)
    );

    fetch_fifo #(
        .WIDTH (ADDR_WIDTH + DATA_WIDTH),
        .DEPTH (DEPTH)
    ) u_instr_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (redirect_valid),
        .push  (fifo_push),
        .din   ({tag_head, wb.wb_dat_i}),
        .pop   (instr_pop),
        .dout  (fifo_dout),
        .count (fifo_count)
    );

    assign instr_valid = (fifo_count != '0);
    assign instr_pc    = fifo_dout[ADDR_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
    assign instr_data  = fifo_dout[DATA_WIDTH-1:0];

`ifdef FETCH_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (instr_ready && !instr_valid && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stat_stall_cnt = stall_cnt_q;
`endif

endmodule
